// File: rtl/gfg_pkg.sv
`default_nettype none
// ============================================================================
// Package     : gfg_pkg
// Description : Shared types and helpers for the graphics frame-generation
//               blocks. It holds the depth-test FSM state encoding, the
//               {colour, z} pixel pack/unpack helpers and the far-z constant.
// Revision    : 1.0 - initial release
// ============================================================================
package gfg_pkg;

  // Depth-test writer states
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CLEAR   = 3'd1,
    ST_ACCEPT  = 3'd2,
    ST_LOOKUP  = 3'd3,
    ST_COMPARE = 3'd4
  } state_e;

  // The helpers work on a wide carrier so they serve any colour/z width.
  // Callers cast in and truncate out.
  localparam int unsigned PIX_MAX_W = 64;
  typedef logic [PIX_MAX_W-1:0] pix_wide_t;

  // Farthest depth: all ones in the low z_w bits
  function automatic pix_wide_t far_z(input int unsigned z_w);
    return (pix_wide_t'(1) << z_w) - pix_wide_t'(1);
  endfunction

  // Pixel layout is {colour, z}, colour in the MSBs
  function automatic pix_wide_t pack_pixel(input pix_wide_t color,
                                           input pix_wide_t z,
                                           input int unsigned z_w);
    return (color << z_w) | (z & far_z(z_w));
  endfunction

  function automatic pix_wide_t unpack_z(input pix_wide_t pix,
                                         input int unsigned z_w);
    return pix & far_z(z_w);
  endfunction

  function automatic pix_wide_t unpack_color(input pix_wide_t pix,
                                             input int unsigned z_w);
    return pix >> z_w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/raster_scan_counter.sv
`default_nettype none
// ============================================================================
// Module      : raster_scan_counter
// Description : Row/column address generator walking a V x H frame in raster
//               order. Column increments each advance and wraps to 0, bumping
//               the row. o_last flags the final pixel (V-1, H-1).
// Revision    : 1.0 - initial release
// ============================================================================
module raster_scan_counter #(
  parameter int unsigned V = 60,
  parameter int unsigned H = 80
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_clear,
  input  logic                 i_advance,
  output logic [$clog2(V)-1:0] o_vert,
  output logic [$clog2(H)-1:0] o_horiz,
  output logic                 o_last
);

  localparam int unsigned V_W = $clog2(V);
  localparam int unsigned H_W = $clog2(H);

  logic [V_W-1:0] vert_q, vert_d;
  logic [H_W-1:0] horiz_q, horiz_d;
  logic           w_h_end;
  logic           w_v_end;

  // Compare at 32 bits so a power-of-two resolution cannot alias to zero
  assign w_h_end = (32'(horiz_q) == H - 1);
  assign w_v_end = (32'(vert_q) == V - 1);
  assign o_last  = w_h_end & w_v_end;
  assign o_vert  = vert_q;
  assign o_horiz = horiz_q;

  // Next address: clear has priority over advance
  always_comb begin
    vert_d  = vert_q;
    horiz_d = horiz_q;
    if (i_clear) begin
      vert_d  = '0;
      horiz_d = '0;
    end else if (i_advance) begin
      if (w_h_end) begin
        horiz_d = '0;
        vert_d  = w_v_end ? '0 : vert_q + V_W'(1);
      end else begin
        horiz_d = horiz_q + H_W'(1);
      end
    end
  end

  // Address registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      vert_q  <= '0;
      horiz_q <= '0;
    end else begin
      vert_q  <= vert_d;
      horiz_q <= horiz_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/depth_test_writer.sv
`default_nettype none
// ============================================================================
// Module      : depth_test_writer
// Description : Clears the target buffer to background colour / far depth at
//               each frame start, then runs a read-compare-write depth test
//               for every incoming fragment (one fragment per 3 cycles).
//               Pulses o_frame_done after the last fragment's compare.
// Revision    : 1.0 - initial release
// ============================================================================
module depth_test_writer
  import gfg_pkg::*;
#(
  parameter int unsigned VERT_RESOLUTION  = 60,
  parameter int unsigned HORIZ_RESOLUTION = 80,
  parameter int unsigned COLOR_DEPTH      = 12,
  parameter int unsigned Z_DEPTH          = 2,
  parameter logic [COLOR_DEPTH-1:0] CLEAR_COLOR = '0
) (
  input  logic                                i_sys_clk,
  input  logic                                i_sys_rst,
  input  logic                                i_frame_start,
  input  logic                                i_frag_valid,
  output logic                                o_frag_ready,
  input  logic [$clog2(VERT_RESOLUTION)-1:0]  i_frag_vert,
  input  logic [$clog2(HORIZ_RESOLUTION)-1:0] i_frag_horiz,
  input  logic [COLOR_DEPTH-1:0]              i_frag_color,
  input  logic [Z_DEPTH-1:0]                  i_frag_z,
  input  logic                                i_frag_last,
  output logic [$clog2(VERT_RESOLUTION)-1:0]  o_vert_write_addr,
  output logic [$clog2(HORIZ_RESOLUTION)-1:0] o_horiz_write_addr,
  output logic [$clog2(VERT_RESOLUTION)-1:0]  o_vert_read_addr,
  output logic [$clog2(HORIZ_RESOLUTION)-1:0] o_horiz_read_addr,
  output logic                                o_write_en,
  output logic [COLOR_DEPTH+Z_DEPTH-1:0]      o_write_pixel_data,
  input  logic [COLOR_DEPTH+Z_DEPTH-1:0]      i_read_pixel_data,
  output logic                                o_busy,
  output logic                                o_frame_done
);

  localparam int unsigned V_W   = $clog2(VERT_RESOLUTION);
  localparam int unsigned H_W   = $clog2(HORIZ_RESOLUTION);
  localparam int unsigned PIX_W = COLOR_DEPTH + Z_DEPTH;

  state_e                 state_q, state_d;
  logic [V_W-1:0]         frag_vert_q, frag_vert_d;
  logic [H_W-1:0]         frag_horiz_q, frag_horiz_d;
  logic [COLOR_DEPTH-1:0] frag_color_q, frag_color_d;
  logic [Z_DEPTH-1:0]     frag_z_q, frag_z_d;
  logic                   frag_last_q, frag_last_d;
  logic                   frame_done_q, frame_done_d;

  logic [V_W-1:0]   w_scan_vert;
  logic [H_W-1:0]   w_scan_horiz;
  logic             w_scan_last;
  logic             w_scan_advance;
  logic [Z_DEPTH-1:0] w_stored_z;
  logic             w_in_range;
  logic             w_write_en;
  logic [PIX_W-1:0] w_clear_pixel;
  logic [PIX_W-1:0] w_frag_pixel;
  logic [V_W-1:0]   w_addr_vert;
  logic [H_W-1:0]   w_addr_horiz;

  // Clear sweeps only while in CLEAR; a frame-start abort freezes the sweep
  // for that cycle and rewinds it to (0,0).
  assign w_scan_advance = (state_q == ST_CLEAR) & ~i_frame_start;

  raster_scan_counter #(
    .V (VERT_RESOLUTION),
    .H (HORIZ_RESOLUTION)
  ) u_clear_scan (
    .i_clk     (i_sys_clk),
    .i_rst     (i_sys_rst),
    .i_clear   (i_frame_start),
    .i_advance (w_scan_advance),
    .o_vert    (w_scan_vert),
    .o_horiz   (w_scan_horiz),
    .o_last    (w_scan_last)
  );

  assign w_stored_z = Z_DEPTH'(unpack_z(pix_wide_t'(i_read_pixel_data), Z_DEPTH));
  assign w_in_range = (32'(frag_vert_q) < VERT_RESOLUTION) &
                      (32'(frag_horiz_q) < HORIZ_RESOLUTION);

  assign w_clear_pixel = PIX_W'(pack_pixel(pix_wide_t'(CLEAR_COLOR),
                                           far_z(Z_DEPTH), Z_DEPTH));
  assign w_frag_pixel  = PIX_W'(pack_pixel(pix_wide_t'(frag_color_q),
                                           pix_wide_t'(frag_z_q), Z_DEPTH));

  // One address drives both RAM ports: the sweep during CLEAR, else the
  // latched fragment coordinates.
  assign w_addr_vert  = (state_q == ST_CLEAR) ? w_scan_vert  : frag_vert_q;
  assign w_addr_horiz = (state_q == ST_CLEAR) ? w_scan_horiz : frag_horiz_q;

  assign o_vert_write_addr  = w_addr_vert;
  assign o_horiz_write_addr = w_addr_horiz;
  assign o_vert_read_addr   = w_addr_vert;
  assign o_horiz_read_addr  = w_addr_horiz;
  assign o_write_pixel_data = (state_q == ST_CLEAR) ? w_clear_pixel : w_frag_pixel;
  assign o_write_en         = w_write_en;
  assign o_frag_ready       = (state_q == ST_ACCEPT);
  assign o_busy             = (state_q == ST_CLEAR) | (state_q == ST_LOOKUP) |
                              (state_q == ST_COMPARE);
  assign o_frame_done       = frame_done_q;

  // Next-state, fragment latch and write strobe; frame start overrides all
  always_comb begin
    state_d      = state_q;
    frag_vert_d  = frag_vert_q;
    frag_horiz_d = frag_horiz_q;
    frag_color_d = frag_color_q;
    frag_z_d     = frag_z_q;
    frag_last_d  = frag_last_q;
    frame_done_d = 1'b0;
    w_write_en   = 1'b0;
    if (i_frame_start) begin
      state_d      = ST_CLEAR;
      frag_vert_d  = '0;
      frag_horiz_d = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          state_d = ST_IDLE;
        end
        ST_CLEAR: begin
          w_write_en = 1'b1;
          if (w_scan_last) begin
            state_d = ST_ACCEPT;
          end
        end
        ST_ACCEPT: begin
          if (i_frag_valid) begin
            frag_vert_d  = i_frag_vert;
            frag_horiz_d = i_frag_horiz;
            frag_color_d = i_frag_color;
            frag_z_d     = i_frag_z;
            frag_last_d  = i_frag_last;
            state_d      = ST_LOOKUP;
          end
        end
        ST_LOOKUP: begin
          state_d = ST_COMPARE;
        end
        ST_COMPARE: begin
          // Strictly nearer wins; equal depth keeps the stored pixel
          w_write_en = w_in_range & (frag_z_q < w_stored_z);
          if (frag_last_q) begin
            state_d      = ST_IDLE;
            frame_done_d = 1'b1;
          end else begin
            state_d = ST_ACCEPT;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // State and fragment registers
  always_ff @(posedge i_sys_clk) begin
    if (i_sys_rst) begin
      state_q      <= ST_IDLE;
      frag_vert_q  <= '0;
      frag_horiz_q <= '0;
      frag_color_q <= '0;
      frag_z_q     <= '0;
      frag_last_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      frag_vert_q  <= frag_vert_d;
      frag_horiz_q <= frag_horiz_d;
      frag_color_q <= frag_color_d;
      frag_z_q     <= frag_z_d;
      frag_last_q  <= frag_last_d;
      frame_done_q <= frame_done_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_depth_test_writer.sv
`default_nettype none
// ============================================================================
// Module      : tb_depth_test_writer
// Description : Self-checking bench for depth_test_writer with a behavioural
//               frame-buffer RAM and an image-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_depth_test_writer;

  localparam int V  = 60;
  localparam int H  = 80;
  localparam int VW = 6;
  localparam int HW = 7;
  localparam int PW = 14;

  logic          clk = 1'b0;
  logic          i_sys_rst;
  logic          i_frame_start;
  logic          i_frag_valid;
  logic          o_frag_ready;
  logic [VW-1:0] i_frag_vert;
  logic [HW-1:0] i_frag_horiz;
  logic [11:0]   i_frag_color;
  logic [1:0]    i_frag_z;
  logic          i_frag_last;
  logic [VW-1:0] o_vert_write_addr, o_vert_read_addr;
  logic [HW-1:0] o_horiz_write_addr, o_horiz_read_addr;
  logic          o_write_en;
  logic [PW-1:0] o_write_pixel_data;
  logic [PW-1:0] i_read_pixel_data;
  logic          o_busy;
  logic          o_frame_done;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  depth_test_writer dut (
    .i_sys_clk          (clk),
    .i_sys_rst          (i_sys_rst),
    .i_frame_start      (i_frame_start),
    .i_frag_valid       (i_frag_valid),
    .o_frag_ready       (o_frag_ready),
    .i_frag_vert        (i_frag_vert),
    .i_frag_horiz       (i_frag_horiz),
    .i_frag_color       (i_frag_color),
    .i_frag_z           (i_frag_z),
    .i_frag_last        (i_frag_last),
    .o_vert_write_addr  (o_vert_write_addr),
    .o_horiz_write_addr (o_horiz_write_addr),
    .o_vert_read_addr   (o_vert_read_addr),
    .o_horiz_read_addr  (o_horiz_read_addr),
    .o_write_en         (o_write_en),
    .o_write_pixel_data (o_write_pixel_data),
    .i_read_pixel_data  (i_read_pixel_data),
    .o_busy             (o_busy),
    .o_frame_done       (o_frame_done)
  );

  // Frame-buffer RAM: synchronous write, registered read (one-cycle latency)
  logic [PW-1:0] fb    [0:63][0:127];
  logic [PW-1:0] model [0:63][0:127];
  logic [PW-1:0] rd_q;
  assign i_read_pixel_data = rd_q;

  always @(posedge clk) begin
    if (i_sys_rst) begin
      for (int v = 0; v < 64; v++)
        for (int h = 0; h < 128; h++)
          fb[v][h] <= '0;
      rd_q <= '0;
    end else begin
      if (o_write_en) fb[o_vert_write_addr][o_horiz_write_addr] <= o_write_pixel_data;
      rd_q <= fb[o_vert_read_addr][o_horiz_read_addr];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // All tasks enter and leave at 1 time unit after a rising edge
  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  task automatic pulse_start();
    i_frame_start = 1'b1;
    next_cycle();
    i_frame_start = 1'b0;
  endtask

  // Reference image right after a clear: background colour 0, far depth 3
  task automatic model_clear();
    for (int v = 0; v < 64; v++)
      for (int h = 0; h < 128; h++)
        model[v][h] = (v < V && h < H) ? 14'h0003 : 14'h0000;
  endtask

  // Called in the first cycle after a start; follows the clear to ACCEPT
  task automatic count_clear(input string tag);
    int n = 0, bad = 0, rdy = -1;
    for (int c = 0; c < 6000; c++) begin
      @(negedge clk);
      if (o_frag_ready) begin
        rdy = c;
        break;
      end
      if (o_write_en) begin
        if (o_vert_write_addr !== VW'(n / H) || o_horiz_write_addr !== HW'(n % H) ||
            o_vert_read_addr !== VW'(n / H) || o_horiz_read_addr !== HW'(n % H) ||
            o_write_pixel_data !== 14'h0003 || o_busy !== 1'b1)
          bad++;
        n++;
      end
      next_cycle();
    end
    if (rdy >= 0) next_cycle();
    check({tag, "_write_count"}, n, 4800);
    check({tag, "_raster_order"}, bad, 0);
    check({tag, "_ready_cycle"}, rdy, 4800);
  endtask

  typedef struct {
    logic [VW-1:0] v;
    logic [HW-1:0] h;
    logic [11:0]   c;
    logic [1:0]    z;
    logic          last;
    logic          exp_we;
    logic [PW-1:0] exp_data;
  } vec_t;

  // One fragment, checking each cycle of its handshake/lookup/compare window
  task automatic send_vec(input vec_t t, input int idx);
    string nm = $sformatf("vec%0d", idx);
    i_frag_vert = t.v; i_frag_horiz = t.h; i_frag_color = t.c;
    i_frag_z = t.z; i_frag_last = t.last; i_frag_valid = 1'b1;
    @(negedge clk);
    check({nm, "_hs_ready"}, o_frag_ready, 1);
    next_cycle();
    i_frag_valid = 1'b0;
    @(negedge clk);
    check({nm, "_lookup_busy_ready_we"}, {o_busy, o_frag_ready, o_write_en}, 3'b100);
    next_cycle();
    @(negedge clk);
    check({nm, "_compare_we"}, o_write_en, t.exp_we);
    check({nm, "_compare_addr_data"},
          {o_vert_write_addr, o_horiz_write_addr, o_write_pixel_data},
          {t.v, t.h, t.exp_we ? t.exp_data : {t.c, t.z}});
    next_cycle();
    @(negedge clk);
    if (t.last) begin
      check({nm, "_done_busy_ready"}, {o_frame_done, o_busy, o_frag_ready}, 3'b100);
      next_cycle();
      @(negedge clk);
      check({nm, "_idle_after_done"}, {o_frame_done, o_busy, o_frag_ready}, 3'b000);
    end else begin
      check({nm, "_done_ready"}, {o_frame_done, o_frag_ready}, 2'b01);
    end
    next_cycle();
  endtask

  task automatic drive_rand_frag(input bit last);
    i_frag_vert  = ($urandom_range(0, 7) == 0) ? VW'($urandom_range(0, 63))  : VW'($urandom_range(0, 3));
    i_frag_horiz = ($urandom_range(0, 7) == 0) ? HW'($urandom_range(0, 127)) : HW'($urandom_range(0, 3));
    i_frag_color = 12'($urandom_range(0, 4095));
    i_frag_z     = 2'($urandom_range(0, 3));
    i_frag_last  = last;
  endtask

  // Random frame against the image model; assumes the block is in ACCEPT
  task automatic run_frame(input int nfrag, input bit gaps, input string tag);
    int k = 0, last_hs = -1, gap_bad = 0, dones = 0, cmp_at = -1, we_bad = 0, diffs = 0;
    bit hs;
    logic exp_we;
    logic [PW-1:0] exp_data;
    logic [VW-1:0] ev;
    logic [HW-1:0] eh;
    exp_we = 1'b0; exp_data = '0; ev = '0; eh = '0;
    drive_rand_frag(nfrag == 1);
    i_frag_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
    for (int cyc = 0; cyc < nfrag * 12 + 50; cyc++) begin
      @(negedge clk);
      hs = i_frag_valid && o_frag_ready;
      if (o_frame_done) dones++;
      if (cyc == cmp_at) begin
        if (o_write_en !== exp_we ||
            (exp_we && {o_vert_write_addr, o_horiz_write_addr, o_write_pixel_data} !== {ev, eh, exp_data}))
          we_bad++;
      end
      if (hs) begin
        if (!gaps && last_hs >= 0 && cyc - last_hs != 3) gap_bad++;
        last_hs  = cyc;
        ev       = i_frag_vert;
        eh       = i_frag_horiz;
        exp_data = {i_frag_color, i_frag_z};
        exp_we   = (int'(ev) < V) && (int'(eh) < H) && (i_frag_z < model[ev][eh][1:0]);
        if (exp_we) model[ev][eh] = exp_data;
        cmp_at = cyc + 2;
        k++;
      end
      if (k == nfrag && cyc >= last_hs + 5) break;
      next_cycle();
      if (k < nfrag) begin
        if (hs) drive_rand_frag(k == nfrag - 1);
        i_frag_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      end else begin
        i_frag_valid = 1'b0;
      end
    end
    check({tag, "_handshakes"}, k, nfrag);
    check({tag, "_done_pulses"}, dones, 1);
    check({tag, "_compare_writes"}, we_bad, 0);
    if (!gaps) check({tag, "_handshake_spacing"}, gap_bad, 0);
    check({tag, "_idle_busy_ready"}, {o_busy, o_frag_ready}, 2'b00);
    next_cycle();
    for (int v = 0; v < 64; v++)
      for (int h = 0; h < 128; h++)
        if (fb[v][h] !== model[v][h]) diffs++;
    check({tag, "_image_diffs"}, diffs, 0);
  endtask

  vec_t tbl [10];

  initial begin
    tbl[0] = '{6'd5,  7'd7,  12'hABC, 2'd1, 1'b0, 1'b1, 14'h2AF1}; // depth pass
    tbl[1] = '{6'd5,  7'd7,  12'h123, 2'd1, 1'b0, 1'b0, 14'h0000}; // tie
    tbl[2] = '{6'd5,  7'd7,  12'h456, 2'd2, 1'b0, 1'b0, 14'h0000}; // farther
    tbl[3] = '{6'd5,  7'd7,  12'h789, 2'd0, 1'b0, 1'b1, 14'h1E24}; // nearer
    tbl[4] = '{6'd0,  7'd0,  12'hFFF, 2'd3, 1'b0, 1'b0, 14'h0000}; // tie at far z
    tbl[5] = '{6'd0,  7'd0,  12'hFFF, 2'd2, 1'b0, 1'b1, 14'h3FFE};
    tbl[6] = '{6'd59, 7'd79, 12'h001, 2'd0, 1'b0, 1'b1, 14'h0004}; // corner pixel
    tbl[7] = '{6'd60, 7'd0,  12'h555, 2'd0, 1'b0, 1'b0, 14'h0000}; // row out of range
    tbl[8] = '{6'd0,  7'd80, 12'h666, 2'd0, 1'b0, 1'b0, 14'h0000}; // column out of range
    tbl[9] = '{6'd60, 7'd0,  12'hAAA, 2'd0, 1'b1, 1'b0, 14'h0000}; // out of range, last

    i_sys_rst = 1'b1; i_frame_start = 1'b0; i_frag_valid = 1'b0;
    i_frag_vert = '0; i_frag_horiz = '0; i_frag_color = '0; i_frag_z = '0; i_frag_last = 1'b0;
    repeat (3) next_cycle();

    // Reset state
    @(negedge clk);
    check("rst_ready",  o_frag_ready, 0);
    check("rst_we",     o_write_en, 0);
    check("rst_busy",   o_busy, 0);
    check("rst_done",   o_frame_done, 0);
    check("rst_waddr",  {o_vert_write_addr, o_horiz_write_addr}, 0);
    check("rst_raddr",  {o_vert_read_addr, o_horiz_read_addr}, 0);
    check("rst_data",   o_write_pixel_data, 0);
    next_cycle();
    i_sys_rst = 1'b0;
    @(negedge clk);
    check("idle_ready_busy", {o_frag_ready, o_busy}, 2'b00);
    next_cycle();

    // First clear, then the directed fragment table
    pulse_start();
    count_clear("clear0");
    for (int i = 0; i < 10; i++) send_vec(tbl[i], i);
    check("fb_5_7",   fb[5][7],   14'h1E24);
    check("fb_0_0",   fb[0][0],   14'h3FFE);
    check("fb_59_79", fb[59][79], 14'h0004);
    check("fb_1_1",   fb[1][1],   14'h0003);

    // Abort during LOOKUP of (2,2): no write that cycle, clear restarts at (0,0)
    pulse_start();
    count_clear("clear1");
    i_frag_vert = 6'd2; i_frag_horiz = 7'd2; i_frag_color = 12'h0F0;
    i_frag_z = 2'd0; i_frag_last = 1'b0; i_frag_valid = 1'b1;
    @(negedge clk);
    check("abort_hs_ready", o_frag_ready, 1);
    next_cycle();
    i_frag_valid = 1'b0; i_frame_start = 1'b1;
    @(negedge clk);
    check("abort_lookup_we", o_write_en, 0);
    next_cycle();
    i_frame_start = 1'b0;
    count_clear("clear_after_lookup_abort");

    // Abort mid-clear at pixel 1000
    pulse_start();
    repeat (1000) next_cycle();
    i_frame_start = 1'b1;
    @(negedge clk);
    check("abort_clear_we", o_write_en, 0);
    check("abort_clear_addr", {o_vert_write_addr, o_horiz_write_addr}, {6'd12, 7'd40});
    next_cycle();
    i_frame_start = 1'b0;
    count_clear("clear_after_mid_abort");

    // Back-to-back frame (valid held high), then a frame with random gaps
    pulse_start();
    count_clear("clear2");
    model_clear();
    run_frame(10, 1'b0, "b2b");
    pulse_start();
    count_clear("clear3");
    model_clear();
    run_frame(30, 1'b1, "gaps");

    // Start together with reset: reset wins, block stays idle
    i_sys_rst = 1'b1; i_frame_start = 1'b1;
    next_cycle();
    i_sys_rst = 1'b0; i_frame_start = 1'b0;
    @(negedge clk);
    check("rst_start_idle", {o_busy, o_write_en, o_frag_ready}, 3'b000);
    next_cycle();
    @(negedge clk);
    check("rst_start_idle2", {o_busy, o_write_en, o_frag_ready}, 3'b000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
